// File: rtl/issue_queue_flush_index_returner_pkg.sv
// Shared scheduler constants and types for the issue-queue flush index return port.
package issue_queue_flush_index_returner_pkg;

  localparam int ISSUE_QUEUE_ENTRY_NUM          = 16;
  localparam int ISSUE_QUEUE_RETURN_INDEX_WIDTH = 2;
  localparam int ISSUE_QUEUE_RETURN_INDEX_CYCLE =
    (ISSUE_QUEUE_ENTRY_NUM + ISSUE_QUEUE_RETURN_INDEX_WIDTH - 1) / ISSUE_QUEUE_RETURN_INDEX_WIDTH;

  typedef logic [$clog2(ISSUE_QUEUE_ENTRY_NUM)-1:0]   IssueQueueIndexPath;
  typedef logic [$clog2(ISSUE_QUEUE_ENTRY_NUM+1)-1:0] IssueQueueCountPath;
  typedef logic [ISSUE_QUEUE_ENTRY_NUM-1:0]           IssueQueueOneHotPath;

  typedef enum logic {
    IQ_RET_IDLE,
    IQ_RET_RETURN
  } IssueQueueReturnState;

endpackage

// File: rtl/issue_queue_lowest_two_picker.sv
// Combinational picker: lowest and second-lowest set bits of a mask, as one-hots and indices.
module issue_queue_lowest_two_picker
  import issue_queue_flush_index_returner_pkg::*;
#(
  parameter int ENTRY_NUM = ISSUE_QUEUE_ENTRY_NUM,
  localparam int IDX_W = $clog2(ENTRY_NUM)
) (
  input  logic [ENTRY_NUM-1:0] mask,
  output logic [ENTRY_NUM-1:0] onehot0,
  output logic [ENTRY_NUM-1:0] onehot1,
  output logic [IDX_W-1:0]     idx0,
  output logic [IDX_W-1:0]     idx1,
  output logic                 valid0,
  output logic                 valid1
);

  logic [ENTRY_NUM-1:0] rest;

  // x & -x isolates the lowest set bit
  assign onehot0 = mask & (~mask + ENTRY_NUM'(1));
  assign rest    = mask & ~onehot0;
  assign onehot1 = rest & (~rest + ENTRY_NUM'(1));
  assign valid0  = |mask;
  assign valid1  = |rest;

  always_comb begin
    idx0 = '0;
    idx1 = '0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      if (onehot0[i]) idx0 = IDX_W'(i);
      if (onehot1[i]) idx1 = IDX_W'(i);
    end
  end

endmodule

// File: rtl/issue_queue_flush_index_returner.sv
// Returns flushed issue-queue indices to the free list, two per accepted cycle, lowest first.
// Lane outputs are combinational from the pending mask; busy stalls dispatch until done.
module issue_queue_flush_index_returner
  import issue_queue_flush_index_returner_pkg::*;
#(
  parameter int ENTRY_NUM    = ISSUE_QUEUE_ENTRY_NUM,
  parameter int RETURN_WIDTH = ISSUE_QUEUE_RETURN_INDEX_WIDTH,
  localparam int IDX_W = $clog2(ENTRY_NUM),
  localparam int CNT_W = $clog2(ENTRY_NUM + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flushReq,
  input  logic [ENTRY_NUM-1:0]          flushMask,
  input  logic                          freeListReady,
  output logic [RETURN_WIDTH-1:0]       returnValid,
  output logic [RETURN_WIDTH*IDX_W-1:0] returnIndex,
  output logic                          busy,
  output logic                          done,
  output logic [CNT_W-1:0]              returnedCount
);

  IssueQueueReturnState state;
  logic [ENTRY_NUM-1:0] pending;
  logic [ENTRY_NUM-1:0] next_pending;
  logic [ENTRY_NUM-1:0] merge_mask;
  logic [ENTRY_NUM-1:0] xfer;
  logic [ENTRY_NUM-1:0] onehot0;
  logic [ENTRY_NUM-1:0] onehot1;
  logic [ENTRY_NUM-1:0] seen;
  logic [IDX_W-1:0]     idx0;
  logic [IDX_W-1:0]     idx1;
  logic                 vld0;
  logic                 vld1;
  logic                 active;

  issue_queue_lowest_two_picker #(.ENTRY_NUM(ENTRY_NUM)) u_picker (
    .mask    (pending),
    .onehot0 (onehot0),
    .onehot1 (onehot1),
    .idx0    (idx0),
    .idx1    (idx1),
    .valid0  (vld0),
    .valid1  (vld1)
  );

  assign active       = (state == IQ_RET_RETURN);
  assign busy         = active;
  assign returnValid  = active ? {vld1, vld0} : '0;
  assign returnIndex  = active ? {idx1, idx0} : '0;
  assign xfer         = (active && freeListReady) ? (onehot0 | onehot1) : '0;
  assign merge_mask   = flushReq ? flushMask : '0;
  // Clearing after the merge keeps a bit sent this cycle from being re-queued by a new flush
  assign next_pending = (pending | merge_mask) & ~xfer;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IQ_RET_IDLE;
      pending       <= '0;
      returnedCount <= '0;
      done          <= 1'b0;
    end else begin
      pending <= next_pending;
      done    <= 1'b0;
      if (state == IQ_RET_IDLE) begin
        if (flushReq) begin
          returnedCount <= '0;
          if (|flushMask) state <= IQ_RET_RETURN;
          else            done  <= 1'b1;
        end
      end else begin
        if (freeListReady)
          returnedCount <= returnedCount + CNT_W'(vld0) + CNT_W'(vld1);
        if (next_pending == '0) begin
          state <= IQ_RET_IDLE;
          done  <= 1'b1;
        end
      end
    end
  end

  // Indices handed out since the last start, used only to check for duplicates
  always_ff @(posedge clk) begin
    if (rst)                   seen <= '0;
    else if (!active && flushReq) seen <= '0;
    else                       seen <= seen | xfer;
  end

  a_lanes_distinct: assert property (@(posedge clk) disable iff (rst)
    !(active && vld0 && vld1 && (idx0 == idx1)));
  a_done_not_busy: assert property (@(posedge clk) disable iff (rst)
    !(done && busy));
  a_no_double_return: assert property (@(posedge clk) disable iff (rst)
    ((xfer & seen) == '0));

endmodule

// File: tb/tb_issue_queue_flush_index_returner.sv
// Directed bench: set-based reference model checked every cycle plus literal spot checks.
module tb_issue_queue_flush_index_returner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flushReq = 1'b0;
  logic [15:0] flushMask = '0;
  logic        freeListReady = 1'b1;
  logic [1:0]  returnValid;
  logic [7:0]  returnIndex;
  logic        busy;
  logic        done;
  logic [4:0]  returnedCount;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  // Reference model: set of outstanding indices, a busy flag, a done flag, a counter.
  logic [15:0] m_pend = '0;
  bit          m_busy = 1'b0;
  bit          m_done = 1'b0;
  int          m_count = 0;

  issue_queue_flush_index_returner dut (
    .clk           (clk),
    .rst           (rst),
    .flushReq      (flushReq),
    .flushMask     (flushMask),
    .freeListReady (freeListReady),
    .returnValid   (returnValid),
    .returnIndex   (returnIndex),
    .busy          (busy),
    .done          (done),
    .returnedCount (returnedCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // The two smallest members of the outstanding set.
  function automatic void lowest_two(input logic [15:0] s, output int i0, output int i1,
                                     output bit v0, output bit v1);
    int found = 0;
    i0 = 0; i1 = 0; v0 = 0; v1 = 0;
    for (int i = 0; i < 16; i++) begin
      if (s[i] && found == 0) begin i0 = i; v0 = 1; found = 1; end
      else if (s[i] && found == 1) begin i1 = i; v1 = 1; found = 2; end
    end
  endfunction

  always @(posedge clk) begin
    int i0, i1;
    bit v0, v1;
    logic [15:0] nxt;
    if (rst) begin
      m_pend = '0; m_busy = 0; m_done = 0; m_count = 0;
    end else begin
      lowest_two(m_pend, i0, i1, v0, v1);
      nxt = m_pend | (flushReq ? flushMask : 16'h0);
      if (m_busy && freeListReady) begin
        if (v0) nxt[i0] = 1'b0;
        if (v1) nxt[i1] = 1'b0;
        m_count += int'(v0) + int'(v1);
      end
      m_pend = nxt;
      m_done = 0;
      if (!m_busy) begin
        if (flushReq) begin
          m_count = 0;
          if (flushMask == 16'h0) m_done = 1;
          else                    m_busy = 1;
        end
      end else if (nxt == 16'h0) begin
        m_busy = 0;
        m_done = 1;
      end
    end
  end

  always @(negedge clk) begin
    int i0, i1;
    bit v0, v1;
    if (chk_en) begin
      lowest_two(m_pend, i0, i1, v0, v1);
      if (!m_busy) begin v0 = 0; v1 = 0; end
      check("model_valid", int'(returnValid), int'({v1, v0}));
      if (v0) check("model_idx0", int'(returnIndex[3:0]), i0);
      if (v1) check("model_idx1", int'(returnIndex[7:4]), i1);
      check("model_busy", int'(busy), int'(m_busy));
      check("model_done", int'(done), int'(m_done));
      check("model_count", int'(returnedCount), m_count);
    end
  end

  task automatic drive(input bit req, input logic [15:0] mask, input bit rdy);
    flushReq = req; flushMask = mask; freeListReady = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic lanes(input string name, input int i0, input int v1, input int i1);
    check({name, "_v0"}, int'(returnValid[0]), 1);
    check({name, "_i0"}, int'(returnIndex[3:0]), i0);
    check({name, "_v1"}, int'(returnValid[1]), v1);
    if (v1 != 0) check({name, "_i1"}, int'(returnIndex[7:4]), i1);
  endtask

  initial begin
    tick(); tick();
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_valid", int'(returnValid), 0);
    check("rst_count", int'(returnedCount), 0);
    chk_en = 1'b1;
    rst = 1'b0;
    tick();

    // 1: empty flush
    drive(1, 16'h0000, 1); tick(); drive(0, 0, 1);
    check("t1_done", int'(done), 1);
    check("t1_busy", int'(busy), 0);
    check("t1_valid", int'(returnValid), 0);
    check("t1_count", int'(returnedCount), 0);
    tick();
    check("t1_done_clr", int'(done), 0);

    // 2: sparse mask
    drive(1, 16'h8421, 1); tick(); drive(0, 0, 1);
    lanes("t2_c1", 0, 1, 5); tick();
    lanes("t2_c2", 10, 1, 15); tick();
    check("t2_done", int'(done), 1);
    check("t2_busy", int'(busy), 0);
    check("t2_count", int'(returnedCount), 4);
    tick();

    // 3: full mask
    drive(1, 16'hFFFF, 1); tick(); drive(0, 0, 1);
    for (int k = 0; k < 8; k++) begin
      check("t3_busy", int'(busy), 1);
      lanes("t3", 2 * k, 1, 2 * k + 1);
      tick();
    end
    check("t3_busy_end", int'(busy), 0);
    check("t3_done", int'(done), 1);
    check("t3_count", int'(returnedCount), 16);
    tick();

    // 4: backpressure holds lanes
    drive(1, 16'h0007, 0); tick(); drive(0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      lanes("t4_hold", 0, 1, 1);
      tick();
    end
    drive(0, 0, 1);
    lanes("t4_x1", 0, 1, 1); tick();
    lanes("t4_x2", 2, 0, 0); tick();
    check("t4_done", int'(done), 1);
    check("t4_count", int'(returnedCount), 3);
    tick();

    // 5: merge while busy
    drive(1, 16'h00F0, 1); tick();
    drive(1, 16'h0011, 1);
    lanes("t5_c1", 4, 1, 5); tick(); drive(0, 0, 1);
    lanes("t5_c2", 0, 1, 6); tick();
    lanes("t5_c3", 7, 0, 0); tick();
    check("t5_done", int'(done), 1);
    check("t5_count", int'(returnedCount), 5);
    tick();

    // 6: reset mid-return
    drive(1, 16'hFFFF, 1); tick(); drive(0, 0, 1);
    tick(); tick();
    lanes("t6_pre", 4, 1, 5);
    rst = 1'b1; tick(); rst = 1'b0;
    check("t6_busy", int'(busy), 0);
    check("t6_valid", int'(returnValid), 0);
    check("t6_done", int'(done), 0);
    check("t6_count", int'(returnedCount), 0);
    tick();
    check("t6_no_done", int'(done), 0);
    tick();

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
